// File: rtl/rvfi_mon_pkg.sv
// rvfi_mon_pkg: shared types and constants for the RVFI retirement-flow monitor.
//   state_t    - monitor FSM state encoding (S_COLD, S_WARM, S_TRACK, S_FAIL)
//   err_code_t - first-error code reported on o_err_code
//   OPC_BRANCH - insn[6:2] of conditional branches
//   PC_STEP    - fall-through PC increment (no compressed support)
package rvfi_mon_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_COLD  = 2'd0;  // no packet seen since reset
    localparam state_t S_WARM  = 2'd1;  // packets seen, warm-up not complete
    localparam state_t S_TRACK = 2'd2;  // armed, chain checks active
    localparam state_t S_FAIL  = 2'd3;  // terminal until reset

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_ORDER = 3'd1,
        ERR_CHAIN = 3'd2,
        ERR_ALIGN = 3'd3,
        ERR_STALL = 3'd4
    } err_code_t;

    localparam logic [4:0]  OPC_BRANCH = 5'b11000;
    localparam logic [31:0] PC_STEP    = 32'd4;

endpackage

// File: rtl/rvfi_mon_stall_wdog.sv
// rvfi_mon_stall_wdog: counts idle cycles between retirement strobes and flags when
// the gap reaches MAX_STALL. The count saturates at MAX_STALL and clears on valid.
// Ports:
//   clk     - system clock
//   i_rst   - synchronous active-high reset
//   valid   - retirement strobe (clears the count)
//   active  - monitor has left its cold state; counting is enabled
//   hit     - idle gap has reached MAX_STALL
module rvfi_mon_stall_wdog #(
    parameter int unsigned MAX_STALL = 64
) (
    input  logic clk,
    input  logic i_rst,
    input  logic valid,
    input  logic active,
    output logic hit
);

    localparam int unsigned    W     = $clog2(MAX_STALL + 1);
    localparam logic [W-1:0]   LIMIT = W'(MAX_STALL);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (valid) begin
            cnt_q <= '0;
        end else if (active && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hit = (cnt_q == LIMIT);

endmodule

// File: rtl/rvfi_flow_monitor.sv
// rvfi_flow_monitor: retirement-stream monitor placed downstream of an RVFI port.
// Tracks warm-up after reset/trap, checks order continuity, PC chaining and PC
// alignment, and classifies retired conditional branches. Errors are sticky: the
// first one latches its code and rvfi_order until reset.
// Optional feature: define RVFI_MON_STALL_EN to add an idle-gap watchdog (code 4).
// Ports:
//   clk, i_rst        - clock, synchronous active-high reset
//   rvfi_*            - RVFI retirement packet (valid, order, insn, trap, intr, pc)
//   o_armed           - warm-up complete, chain checks active
//   o_retired         - saturating count of non-trap retirements
//   o_br_valid        - one-cycle pulse: a conditional branch retired
//   o_br_taken        - branch outcome, qualified by o_br_valid
//   o_br_funct3       - branch funct3, qualified by o_br_valid
//   o_fail            - sticky error flag
//   o_err_code        - first error code (see err_code_t)
//   o_fail_order      - rvfi_order associated with the first error
module rvfi_flow_monitor
    import rvfi_mon_pkg::*;
#(
    parameter int unsigned WARMUP    = 2,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_STALL = 64
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             rvfi_valid,
    input  logic [63:0]      rvfi_order,
    input  logic [31:0]      rvfi_insn,
    input  logic             rvfi_trap,
    input  logic             rvfi_intr,
    input  logic [31:0]      rvfi_pc_rdata,
    input  logic [31:0]      rvfi_pc_wdata,
    output logic             o_armed,
    output logic [CNT_W-1:0] o_retired,
    output logic             o_br_valid,
    output logic             o_br_taken,
    output logic [2:0]       o_br_funct3,
    output logic             o_fail,
    output logic [2:0]       o_err_code,
    output logic [63:0]      o_fail_order
);

    localparam int unsigned          WARM_W   = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [WARM_W-1:0]    WARM_MAX = WARM_W'(WARMUP);

    state_t             state_q, state_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic               prev_valid_q;
    logic               prev_trap_q;
    logic [31:0]        prev_pc_wdata_q;
    logic [63:0]        prev_order_q;
    logic [CNT_W-1:0]   retired_q;
    logic               armed_q;
    logic               br_valid_q, br_taken_q;
    logic [2:0]         br_funct3_q;
    logic               fail_q;
    err_code_t          err_code_q;
    logic [63:0]        fail_order_q;

    logic               pkt_ok;
    logic               is_branch;
    logic               err_order, err_chain, err_align;
    logic               stall_hit;
    logic               err_any;
    err_code_t          new_code;

    // Only the opcode and funct3 fields of the instruction are inspected.
    logic unused_insn;
    assign unused_insn = ^{rvfi_insn[31:15], rvfi_insn[11:7], rvfi_insn[1:0]};

`ifdef RVFI_MON_STALL_EN
    rvfi_mon_stall_wdog #(
        .MAX_STALL (MAX_STALL)
    ) u_stall_wdog (
        .clk    (clk),
        .i_rst  (i_rst),
        .valid  (rvfi_valid),
        .active (state_q != S_COLD),
        .hit    (stall_hit)
    );
`else
    localparam int unsigned unused_max_stall = MAX_STALL;
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        pkt_ok    = rvfi_valid && !rvfi_trap;
        is_branch = pkt_ok && (rvfi_insn[6:2] == OPC_BRANCH);

        err_order = rvfi_valid && prev_valid_q && (rvfi_order != prev_order_q + 64'd1);
        // Chaining is waived after a trap and on the first handler instruction.
        err_chain = rvfi_valid && (state_q == S_TRACK) && !prev_trap_q && !rvfi_intr &&
                    (rvfi_pc_rdata != prev_pc_wdata_q);
        err_align = pkt_ok && (rvfi_pc_wdata[1:0] != 2'b00);

        if (err_order) begin
            new_code = ERR_ORDER;
        end else if (err_chain) begin
            new_code = ERR_CHAIN;
        end else if (err_align) begin
            new_code = ERR_ALIGN;
        end else if (stall_hit) begin
            new_code = ERR_STALL;
        end else begin
            new_code = ERR_NONE;
        end

        // Checks stop once failed so the first error stays recorded.
        err_any = (state_q != S_FAIL) && (new_code != ERR_NONE);
    end

    always_comb begin
        warm_cnt_d = warm_cnt_q;
        state_d    = state_q;

        if (rvfi_valid) begin
            if (rvfi_trap) begin
                warm_cnt_d = '0;
            end else if (warm_cnt_q != WARM_MAX) begin
                warm_cnt_d = warm_cnt_q + 1'b1;
            end
        end

        if ((state_q != S_FAIL) && rvfi_valid) begin
            if (rvfi_trap) begin
                state_d = S_WARM;
            end else begin
                state_d = (warm_cnt_d == WARM_MAX) ? S_TRACK : S_WARM;
            end
        end

        if (err_any) begin
            state_d = S_FAIL;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q         <= S_COLD;
            warm_cnt_q      <= '0;
            prev_valid_q    <= 1'b0;
            prev_trap_q     <= 1'b0;
            prev_pc_wdata_q <= '0;
            prev_order_q    <= '0;
            retired_q       <= '0;
            armed_q         <= 1'b0;
            br_valid_q      <= 1'b0;
            br_taken_q      <= 1'b0;
            br_funct3_q     <= '0;
            fail_q          <= 1'b0;
            err_code_q      <= ERR_NONE;
            fail_order_q    <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;

            if (rvfi_valid) begin
                prev_valid_q    <= 1'b1;
                prev_trap_q     <= rvfi_trap;
                prev_pc_wdata_q <= rvfi_pc_wdata;
                prev_order_q    <= rvfi_order;
            end

            if (pkt_ok && (retired_q != {CNT_W{1'b1}})) begin
                retired_q <= retired_q + 1'b1;
            end

            // Armed mirrors S_TRACK but freezes on entry to S_FAIL.
            if (state_d != S_FAIL) begin
                armed_q <= (state_d == S_TRACK);
            end

            br_valid_q <= is_branch;
            if (is_branch) begin
                br_taken_q  <= (rvfi_pc_wdata != rvfi_pc_rdata + PC_STEP);
                br_funct3_q <= rvfi_insn[14:12];
            end

            if (err_any) begin
                fail_q       <= 1'b1;
                err_code_q   <= new_code;
                fail_order_q <= (new_code == ERR_STALL) ? prev_order_q : rvfi_order;
            end
        end
    end

    assign o_armed      = armed_q;
    assign o_retired    = retired_q;
    assign o_br_valid   = br_valid_q;
    assign o_br_taken   = br_taken_q;
    assign o_br_funct3  = br_funct3_q;
    assign o_fail       = fail_q;
    assign o_err_code   = err_code_q;
    assign o_fail_order = fail_order_q;

endmodule

// File: tb/tb_rvfi_flow_monitor.sv
// tb_rvfi_flow_monitor: directed scenarios plus randomized retirement streams checked
// against a packet-level reference model of the monitor rules.
module tb_rvfi_flow_monitor;

    localparam int unsigned WARMUP    = 2;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned MAX_STALL = 8;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BEQ = 32'h0020_8463;
    localparam logic [31:0] BNE = 32'h0020_9463;

    logic             clk = 1'b0;
    logic             i_rst;
    logic             rvfi_valid;
    logic [63:0]      rvfi_order;
    logic [31:0]      rvfi_insn;
    logic             rvfi_trap;
    logic             rvfi_intr;
    logic [31:0]      rvfi_pc_rdata;
    logic [31:0]      rvfi_pc_wdata;
    logic             o_armed;
    logic [CNT_W-1:0] o_retired;
    logic             o_br_valid;
    logic             o_br_taken;
    logic [2:0]       o_br_funct3;
    logic             o_fail;
    logic [2:0]       o_err_code;
    logic [63:0]      o_fail_order;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, kept in terms of packets seen rather than FSM states.
    bit               m_prev_valid, m_prev_trap, m_seen;
    logic [63:0]      m_prev_order;
    logic [31:0]      m_prev_pcw;
    int               m_nontrap, m_stall;
    logic             exp_armed, exp_br_valid, exp_br_taken, exp_fail;
    logic [CNT_W-1:0] exp_retired;
    logic [2:0]       exp_br_funct3, exp_code;
    logic [63:0]      exp_fail_order;

    always #5 clk = ~clk;

    rvfi_flow_monitor #(
        .WARMUP    (WARMUP),
        .CNT_W     (CNT_W),
        .MAX_STALL (MAX_STALL)
    ) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .rvfi_valid    (rvfi_valid),
        .rvfi_order    (rvfi_order),
        .rvfi_insn     (rvfi_insn),
        .rvfi_trap     (rvfi_trap),
        .rvfi_intr     (rvfi_intr),
        .rvfi_pc_rdata (rvfi_pc_rdata),
        .rvfi_pc_wdata (rvfi_pc_wdata),
        .o_armed       (o_armed),
        .o_retired     (o_retired),
        .o_br_valid    (o_br_valid),
        .o_br_taken    (o_br_taken),
        .o_br_funct3   (o_br_funct3),
        .o_fail        (o_fail),
        .o_err_code    (o_err_code),
        .o_fail_order  (o_fail_order)
    );

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [2:0] code;
        if (i_rst) begin
            m_prev_valid = 0; m_prev_trap = 0; m_seen = 0; m_prev_order = '0;
            m_prev_pcw = '0; m_nontrap = 0; m_stall = 0;
            exp_armed = 0; exp_retired = '0; exp_br_valid = 0; exp_br_taken = 0;
            exp_br_funct3 = '0; exp_fail = 0; exp_code = '0; exp_fail_order = '0;
            return;
        end
        exp_br_valid = rvfi_valid && !rvfi_trap && (rvfi_insn[6:2] == 5'b11000);
        if (exp_br_valid) begin
            exp_br_taken  = (rvfi_pc_wdata != rvfi_pc_rdata + 32'd4);
            exp_br_funct3 = rvfi_insn[14:12];
        end
        if (!exp_fail) begin
            code = 3'd0;
            if (rvfi_valid && m_prev_valid && (rvfi_order != m_prev_order + 64'd1)) code = 3'd1;
            else if (rvfi_valid && exp_armed && !m_prev_trap && !rvfi_intr &&
                     (rvfi_pc_rdata != m_prev_pcw)) code = 3'd2;
            else if (rvfi_valid && !rvfi_trap && (rvfi_pc_wdata[1:0] != 2'b00)) code = 3'd3;
`ifdef RVFI_MON_STALL_EN
            else if (m_stall >= MAX_STALL) code = 3'd4;
`endif
            if (code != 3'd0) begin
                exp_fail       = 1;
                exp_code       = code;
                exp_fail_order = (code == 3'd4) ? m_prev_order : rvfi_order;
            end
        end
        if (rvfi_valid) m_stall = 0;
        else if (m_seen && (m_stall < MAX_STALL)) m_stall++;
        if (rvfi_valid) begin
            m_seen = 1; m_prev_valid = 1; m_prev_trap = rvfi_trap;
            m_prev_order = rvfi_order; m_prev_pcw = rvfi_pc_wdata;
            if (rvfi_trap) m_nontrap = 0;
            else begin
                m_nontrap++;
                if (exp_retired != {CNT_W{1'b1}}) exp_retired++;
            end
        end
        if (!exp_fail) exp_armed = m_seen && (m_nontrap >= WARMUP);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] order, input logic [31:0] insn, input bit trap,
                        input bit intr, input logic [31:0] pcr, input logic [31:0] pcw);
        rvfi_valid = 1'b1; rvfi_order = order; rvfi_insn = insn; rvfi_trap = trap;
        rvfi_intr = intr; rvfi_pc_rdata = pcr; rvfi_pc_wdata = pcw;
        tick();
        rvfi_valid = 1'b0; rvfi_trap = 1'b0; rvfi_intr = 1'b0;
    endtask

    task automatic idle(input int n);
        rvfi_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        i_rst = 1'b1; rvfi_valid = 1'b0;
        tick(); tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        if (o_armed !== 1'b0) begin miscompares++; $display("FAIL reset_armed: got %b want 0", o_armed); end vectors++;
        if (o_retired !== '0) begin miscompares++; $display("FAIL reset_retired: got %0d want 0", o_retired); end vectors++;
        if (o_br_valid !== 1'b0) begin miscompares++; $display("FAIL reset_br_valid: got %b want 0", o_br_valid); end vectors++;
        if (o_fail !== 1'b0) begin miscompares++; $display("FAIL reset_fail: got %b want 0", o_fail); end vectors++;
        if (o_err_code !== 3'd0) begin miscompares++; $display("FAIL reset_code: got %0d want 0", o_err_code); end vectors++;
        if (o_fail_order !== 64'd0) begin miscompares++; $display("FAIL reset_fail_order: got %0h want 0", o_fail_order); end vectors++;
    endtask

    task automatic test_warmup();
        send(64'd0, NOP, 0, 0, 32'h100, 32'h104);
        if (o_armed !== 1'b0) begin miscompares++; $display("FAIL warm_armed_p1: got %b want 0", o_armed); end vectors++;
        send(64'd1, NOP, 0, 0, 32'h104, 32'h108);
        if (o_armed !== 1'b1) begin miscompares++; $display("FAIL warm_armed_p2: got %b want 1", o_armed); end vectors++;
        send(64'd2, NOP, 0, 0, 32'h108, 32'h10C);
        if (o_retired !== 16'd3) begin miscompares++; $display("FAIL warm_retired: got %0d want 3", o_retired); end vectors++;
        if (o_fail !== 1'b0) begin miscompares++; $display("FAIL warm_fail: got %b want 0", o_fail); end vectors++;
    endtask

    task automatic test_branch();
        send(64'd3, NOP, 0, 0, 32'h10C, 32'h200);
        send(64'd4, BEQ, 0, 0, 32'h200, 32'h208);
        if (o_br_valid !== 1'b1) begin miscompares++; $display("FAIL beq_taken_valid: got %b want 1", o_br_valid); end vectors++;
        if (o_br_taken !== 1'b1) begin miscompares++; $display("FAIL beq_taken: got %b want 1", o_br_taken); end vectors++;
        if (o_br_funct3 !== 3'd0) begin miscompares++; $display("FAIL beq_funct3: got %0d want 0", o_br_funct3); end vectors++;
        send(64'd5, BEQ, 0, 0, 32'h208, 32'h20C);
        if (o_br_valid !== 1'b1) begin miscompares++; $display("FAIL beq_nt_valid: got %b want 1", o_br_valid); end vectors++;
        if (o_br_taken !== 1'b0) begin miscompares++; $display("FAIL beq_not_taken: got %b want 0", o_br_taken); end vectors++;
        send(64'd6, BNE, 0, 0, 32'h20C, 32'h210);
        if (o_br_funct3 !== 3'd1) begin miscompares++; $display("FAIL bne_funct3: got %0d want 1", o_br_funct3); end vectors++;
        idle(1);
        if (o_br_valid !== 1'b0) begin miscompares++; $display("FAIL br_pulse_end: got %b want 0", o_br_valid); end vectors++;
        if (o_fail !== 1'b0) begin miscompares++; $display("FAIL branch_no_err: got %b want 0", o_fail); end vectors++;
    endtask

    task automatic test_chain_err();
        send(64'd7, NOP, 0, 0, 32'h300, 32'h304);
        if (o_err_code !== 3'd2) begin miscompares++; $display("FAIL chain_code: got %0d want 2", o_err_code); end vectors++;
        if (o_fail !== 1'b1) begin miscompares++; $display("FAIL chain_fail: got %b want 1", o_fail); end vectors++;
        if (o_fail_order !== 64'd7) begin miscompares++; $display("FAIL chain_order: got %0d want 7", o_fail_order); end vectors++;
        if (o_armed !== 1'b1) begin miscompares++; $display("FAIL chain_armed_hold: got %b want 1", o_armed); end vectors++;
        send(64'd8, NOP, 0, 0, 32'h304, 32'h308);
        send(64'd99, NOP, 0, 0, 32'h999, 32'h401);
        if (o_err_code !== 3'd2) begin miscompares++; $display("FAIL chain_sticky_code: got %0d want 2", o_err_code); end vectors++;
        if (o_fail_order !== 64'd7) begin miscompares++; $display("FAIL chain_sticky_order: got %0d want 7", o_fail_order); end vectors++;
        send(64'd100, BEQ, 0, 0, 32'h401, 32'h500);
        if (o_br_valid !== 1'b1 || o_br_taken !== 1'b1) begin
            miscompares++; $display("FAIL br_in_fail: got v=%b t=%b want v=1 t=1", o_br_valid, o_br_taken);
        end vectors++;
    endtask

    task automatic test_trap();
        do_reset();
        send(64'd0, NOP, 0, 0, 32'h100, 32'h104);
        send(64'd1, NOP, 0, 0, 32'h104, 32'h108);
        send(64'd2, NOP, 1, 0, 32'h108, 32'h800);
        if (o_armed !== 1'b0) begin miscompares++; $display("FAIL trap_disarm: got %b want 0", o_armed); end vectors++;
        if (o_retired !== 16'd2) begin miscompares++; $display("FAIL trap_retired: got %0d want 2", o_retired); end vectors++;
        send(64'd3, NOP, 0, 0, 32'h500, 32'h504);
        if (o_fail !== 1'b0) begin miscompares++; $display("FAIL trap_chain_waived: got %b want 0", o_fail); end vectors++;
        if (o_armed !== 1'b0) begin miscompares++; $display("FAIL trap_rewarm1: got %b want 0", o_armed); end vectors++;
        send(64'd4, NOP, 0, 0, 32'h504, 32'h508);
        if (o_armed !== 1'b1) begin miscompares++; $display("FAIL trap_rewarm2: got %b want 1", o_armed); end vectors++;
        send(64'd5, NOP, 0, 1, 32'h700, 32'h704);
        if (o_fail !== 1'b0) begin miscompares++; $display("FAIL intr_chain_waived: got %b want 0", o_fail); end vectors++;
    endtask

    task automatic test_priority();
        do_reset();
        send(64'd5, NOP, 0, 0, 32'h100, 32'h104);
        if (o_fail !== 1'b0) begin miscompares++; $display("FAIL first_pkt_unchecked: got %b want 0", o_fail); end vectors++;
        send(64'd7, NOP, 0, 0, 32'h104, 32'h102);
        if (o_err_code !== 3'd1) begin miscompares++; $display("FAIL order_over_align: got %0d want 1", o_err_code); end vectors++;
        if (o_fail_order !== 64'd7) begin miscompares++; $display("FAIL order_fail_order: got %0d want 7", o_fail_order); end vectors++;
        do_reset();
        send(64'd40, NOP, 0, 0, 32'h100, 32'h103);
        if (o_err_code !== 3'd3) begin miscompares++; $display("FAIL align_code: got %0d want 3", o_err_code); end vectors++;
        if (o_fail_order !== 64'd40) begin miscompares++; $display("FAIL align_order: got %0d want 40", o_fail_order); end vectors++;
    endtask

    task automatic test_midstream_reset();
        do_reset();
        send(64'd10, NOP, 0, 0, 32'h100, 32'h104);
        send(64'd11, NOP, 0, 0, 32'h104, 32'h108);
        i_rst = 1'b1; rvfi_valid = 1'b1;
        tick();
        i_rst = 1'b0; rvfi_valid = 1'b0;
        if (o_armed !== 1'b0 || o_retired !== '0) begin
            miscompares++; $display("FAIL midrst_clear: got armed=%b ret=%0d want 0/0", o_armed, o_retired);
        end vectors++;
        send(64'd500, NOP, 0, 0, 32'h900, 32'h904);
        if (o_fail !== 1'b0) begin miscompares++; $display("FAIL midrst_first_pkt: got %b want 0", o_fail); end vectors++;
    endtask

    task automatic test_stall();
        do_reset();
        idle(MAX_STALL + 2);
        if (o_fail !== 1'b0) begin miscompares++; $display("FAIL stall_cold: got %b want 0", o_fail); end vectors++;
        send(64'd20, NOP, 0, 0, 32'h100, 32'h104);
        idle(MAX_STALL - 1);
        if (o_fail !== 1'b0) begin miscompares++; $display("FAIL stall_early: got %b want 0", o_fail); end vectors++;
        idle(3);
`ifdef RVFI_MON_STALL_EN
        if (o_err_code !== 3'd4) begin miscompares++; $display("FAIL stall_code: got %0d want 4", o_err_code); end vectors++;
        if (o_fail_order !== 64'd20) begin miscompares++; $display("FAIL stall_order: got %0d want 20", o_fail_order); end vectors++;
`else
        if (o_fail !== 1'b0 || o_err_code !== 3'd0) begin
            miscompares++; $display("FAIL stall_disabled: got fail=%b code=%0d want 0/0", o_fail, o_err_code);
        end vectors++;
`endif
    endtask

    task automatic test_random();
        logic [63:0] g_next;
        logic [31:0] g_pc, rnd;
        bit          g_after_trap;
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            g_next = (ep == 0) ? 64'hFFFF_FFFF_FFFF_FFFD : {32'd0, $urandom};
            g_pc   = (ep == 1) ? 32'hFFFF_FFF0 : {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            g_after_trap = 0;
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    rvfi_valid = 1'b0;
                end else begin
                    rnd = $urandom;
                    rvfi_valid    = 1'b1;
                    rvfi_order    = ($urandom_range(0, 99) < 3) ? g_next + 64'd1 : g_next;
                    rvfi_trap     = ($urandom_range(0, 19) == 0);
                    rvfi_intr     = g_after_trap || ($urandom_range(0, 29) == 0);
                    rvfi_pc_rdata = ($urandom_range(0, 99) < 3) ? g_pc ^ 32'h40 : g_pc;
                    rvfi_insn     = ($urandom_range(0, 2) == 0) ? {rnd[31:7], 5'b11000, 2'b11}
                                                                : {rnd[31:7], 5'b00100, 2'b11};
                    rvfi_pc_wdata = $urandom_range(0, 1) ? rvfi_pc_rdata + 32'd4
                                    : rvfi_pc_rdata + {22'd0, 8'($urandom_range(2, 200)), 2'b00};
                    if ($urandom_range(0, 99) < 2) rvfi_pc_wdata[1] = 1'b1;
                    g_next = rvfi_order + 64'd1;
                    g_pc = rvfi_pc_wdata;
                    g_after_trap = rvfi_trap;
                end
                tick();
                rvfi_valid = 1'b0;
                if (o_armed !== exp_armed) begin miscompares++; $display("FAIL rnd_armed ep%0d c%0d: got %b want %b", ep, c, o_armed, exp_armed); end vectors++;
                if (o_retired !== exp_retired) begin miscompares++; $display("FAIL rnd_retired ep%0d c%0d: got %0d want %0d", ep, c, o_retired, exp_retired); end vectors++;
                if (o_br_valid !== exp_br_valid) begin miscompares++; $display("FAIL rnd_br_valid ep%0d c%0d: got %b want %b", ep, c, o_br_valid, exp_br_valid); end vectors++;
                if (exp_br_valid) begin
                    if (o_br_taken !== exp_br_taken) begin miscompares++; $display("FAIL rnd_br_taken ep%0d c%0d: got %b want %b", ep, c, o_br_taken, exp_br_taken); end vectors++;
                    if (o_br_funct3 !== exp_br_funct3) begin miscompares++; $display("FAIL rnd_br_funct3 ep%0d c%0d: got %0d want %0d", ep, c, o_br_funct3, exp_br_funct3); end vectors++;
                end
                if (o_fail !== exp_fail) begin miscompares++; $display("FAIL rnd_fail ep%0d c%0d: got %b want %b", ep, c, o_fail, exp_fail); end vectors++;
                if (o_err_code !== exp_code) begin miscompares++; $display("FAIL rnd_code ep%0d c%0d: got %0d want %0d", ep, c, o_err_code, exp_code); end vectors++;
                if (o_fail_order !== exp_fail_order) begin miscompares++; $display("FAIL rnd_fail_order ep%0d c%0d: got %0h want %0h", ep, c, o_fail_order, exp_fail_order); end vectors++;
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; rvfi_valid = 1'b0; rvfi_order = '0; rvfi_insn = NOP; rvfi_trap = 1'b0;
        rvfi_intr = 1'b0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
        test_reset();
        test_warmup();
        test_branch();
        test_chain_err();
        test_trap();
        test_priority();
        test_midstream_reset();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rvfi_flow_monitor.md
Name: rvfi_flow_monitor

Overview:
- Synthesizable retirement-stream monitor that sits directly downstream of serv_top's RVFI port, and alongside the per-instruction formal checkers.
- Consumes every RVFI packet. Tracks warm-up after reset or trap, checks PC chaining, order continuity and PC alignment, and classifies conditional branches as taken or not taken.
- Produces registered, sticky error status usable as an assert target in formal runs or as a scoreboard input in simulation.

Parameters:
- WARMUP, 2, non-trap retirements needed after reset or a trap before chain checks are armed.
- CNT_W, 16, width of the saturating retirement counter.
- MAX_STALL, 64, watchdog limit in cycles between rvfi_valid pulses (optional feature only).

Ports:
- clk  in  1  system clock.
- i_rst  in  1  reset; synchronous, active-high.
- rvfi_valid  in  1  retirement strobe.
- rvfi_order  in  64  retirement index.
- rvfi_insn  in  32  retired instruction.
- rvfi_trap  in  1  instruction trapped.
- rvfi_intr  in  1  first instruction of a trap/interrupt handler.
- rvfi_pc_rdata  in  32  PC of the retired instruction.
- rvfi_pc_wdata  in  32  next PC.
- o_armed  out  1  warm-up complete; chain checks active.
- o_retired  out  CNT_W  non-trap retirements since reset; saturates at all-ones.
- o_br_valid  out  1  one-cycle pulse: a branch retired.
- o_br_taken  out  1  branch outcome; qualified by o_br_valid.
- o_br_funct3  out  3  branch funct3; qualified by o_br_valid.
- o_fail  out  1  sticky: any error seen.
- o_err_code  out  3  first error: 0 none, 1 order, 2 pc-chain, 3 align, 4 stall.
- o_fail_order  out  64  rvfi_order of the first failing packet.

Behaviour:
- Clock and reset: one clock (clk). Reset i_rst is synchronous and active-high.
- Reset values: all outputs 0. State S_COLD. Warm-up counter 0. prev_valid 0.
- FSM states:
  - S_COLD: no packet seen yet.
  - S_WARM: packets seen; warm-up counter < WARMUP.
  - S_TRACK: armed.
  - S_FAIL: terminal until reset.
- FSM transitions:
  - S_COLD -> S_WARM on the first rvfi_valid.
  - S_WARM -> S_TRACK when the counter reaches WARMUP.
  - S_TRACK or S_WARM -> S_WARM on a valid packet with rvfi_trap=1; the warm-up counter clears to 0.
  - Any state -> S_FAIL on a detected error.
- o_armed = 1 exactly in S_TRACK. In S_FAIL it holds its last value.
- Each valid packet updates: prev_pc_wdata, prev_order, prev_trap.
- Each valid non-trap packet also does: warm-up counter += 1 (saturating at WARMUP); o_retired += 1 (saturating).
- Order check: applies to every valid packet when prev_valid=1. Error if rvfi_order != prev_order + 1 (64-bit wrap permitted).
- PC-chain check: applies only when all of these hold:
  - state is S_TRACK;
  - prev_trap=0;
  - rvfi_intr=0.
  Error if rvfi_pc_rdata != prev_pc_wdata.
- Align check: valid and rvfi_trap=0 and rvfi_pc_wdata[1:0] != 0 (no compressed support).
- Simultaneous errors: record one code by priority order > chain > align > stall.
- Latency: all outputs registered, one cycle after the sampled packet. o_fail, o_err_code and o_fail_order latch on the first error and never change until reset.
- Branch classification: applies to valid, non-trap packets with insn[6:2]=5'b11000.
  - o_br_valid pulses next cycle.
  - o_br_taken = (pc_wdata != pc_rdata + 32'd4), 32-bit wrap.
  - o_br_funct3 = insn[14:12].
  - Classification continues in S_FAIL; error checks stop.
- Back-to-back packets (valid on consecutive cycles) must be supported at full rate.
- Reset asserted mid-stream: the next cycle is S_COLD. The first post-reset packet is not order-checked.

Optional Feature:
- Macro: RVFI_MON_STALL_EN.
- When defined:
  - A counter increments each cycle outside S_COLD with rvfi_valid=0, and clears on rvfi_valid.
  - When it reaches MAX_STALL, error code 4 is raised; o_fail_order = prev_order.
  - The counter saturates.
- When undefined: no counter is instantiated, and code 4 is never produced.

Decomposition:
- Package rvfi_mon_pkg holds:
  - state enum (S_COLD, S_WARM, S_TRACK, S_FAIL);
  - 3-bit err_code_t with named values;
  - OPC_BRANCH = 5'b11000;
  - PC_STEP = 32'd4.
- Sub-module rvfi_mon_stall_wdog: the stall counter and compare, instantiated only under RVFI_MON_STALL_EN.

Test Plan:
- Reset, then 3 valid packets: order 0,1,2; pc_rdata 0x100/0x104/0x108; pc_wdata = +4 -> o_armed=1 after the 2nd packet, o_retired=3, o_fail=0.
- Armed, then BEQ insn 0x00208463 at pc 0x200 with pc_wdata 0x208 -> o_br_valid pulse, o_br_taken=1, o_br_funct3=0. Same insn with pc_wdata 0x204 -> o_br_taken=0.
- Armed, then next packet pc_rdata 0x300 while prev_pc_wdata is 0x10C -> o_err_code=2, o_fail=1, o_fail_order = that order. A later clean packet leaves the code unchanged.
- Trap packet, then a packet with mismatched pc_rdata and intr=0 -> no error. o_armed=0 until 2 further non-trap packets.
- Order jumps 5 -> 7 with pc_wdata 0x102 in the same packet -> o_err_code=1 (priority over align).
- With RVFI_MON_STALL_EN and MAX_STALL=8: one packet, then 8 idle cycles -> o_err_code=4. Without the macro: no error.
